// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch and data ports: data wins ties, a bounded starvation
// counter forces fetch through; one grant per cycle, registered response one cycle later, no backpressure.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        ireq_valid_i,
   output logic        ireq_ready_o,
   input  logic [31:0] ireq_addr_i,
   input  logic [1:0]  ireq_size_i,
   output logic        irsp_valid_o,
   output logic [31:0] irsp_data_o,
   output logic        irsp_err_o,
   input  logic        dreq_valid_i,
   output logic        dreq_ready_o,
   input  logic        dreq_write_i,
   input  logic [31:0] dreq_addr_i,
   input  logic [1:0]  dreq_size_i,
   input  logic [31:0] dreq_wdata_i,
   output logic        drsp_valid_o,
   output logic [31:0] drsp_data_o,
   output logic        drsp_err_o,
   output logic [31:0] memif_rd_addr,
   output logic [1:0]  memif_rd_size,
   input  logic [31:0] memif_rd_data,
   output logic [31:0] memif_wr_addr,
   output logic [1:0]  memif_wr_size,
   output logic [31:0] memif_wr_data,
   output logic        memif_wr_enable
);

   // mem_access_size_t encoding
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_cnt;
   logic          i_gnt, d_gnt, any_gnt;
   logic [31:0]   g_addr;
   logic [1:0]    g_size;
   logic          g_write, g_mis, g_fwd;
   logic [31:0]   rd_masked;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return lsb[0];
         default: return lsb != 2'b00;
      endcase
   endfunction

   function automatic logic [31:0] size_mask(input logic [1:0] size);
      case (size)
         SZ_BYTE: return 32'h0000_00FF;
         SZ_HALF: return 32'h0000_FFFF;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   // Grants are gated by reset so a same-cycle access neither writes nor responds.
   assign i_gnt   = !reset_i && ireq_valid_i && (!dreq_valid_i || starve_cnt == LIMIT);
   assign d_gnt   = !reset_i && dreq_valid_i && !i_gnt;
   assign any_gnt = i_gnt || d_gnt;

   assign ireq_ready_o = i_gnt;
   assign dreq_ready_o = d_gnt;

   assign g_addr    = d_gnt ? dreq_addr_i : ireq_addr_i;
   assign g_size    = d_gnt ? dreq_size_i : ireq_size_i;
   assign g_write   = d_gnt && dreq_write_i;
   assign g_mis     = misaligned(g_size, g_addr[1:0]);
   assign g_fwd     = any_gnt && !g_mis;
   assign rd_masked = memif_rd_data & size_mask(g_size);

   always_comb begin
      memif_rd_addr   = 32'h0;
      memif_rd_size   = SZ_WORD;
      memif_wr_addr   = 32'h0;
      memif_wr_size   = SZ_WORD;
      memif_wr_data   = 32'h0;
      memif_wr_enable = 1'b0;
      if (g_fwd) begin
         memif_rd_addr = g_addr;
         memif_rd_size = g_size;
         if (g_write) begin
            memif_wr_addr   = g_addr;
            memif_wr_size   = g_size;
            memif_wr_data   = dreq_wdata_i;
            memif_wr_enable = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         starve_cnt   <= '0;
         irsp_valid_o <= 1'b0;
         irsp_data_o  <= 32'h0;
         irsp_err_o   <= 1'b0;
         drsp_valid_o <= 1'b0;
         drsp_data_o  <= 32'h0;
         drsp_err_o   <= 1'b0;
      end else begin
         // A data grant with fetch waiting implies starve_cnt < LIMIT, so this cannot overflow.
         if (d_gnt && ireq_valid_i)
            starve_cnt <= starve_cnt + CW'(1);
         else
            starve_cnt <= '0;

         irsp_valid_o <= i_gnt;
         drsp_valid_o <= d_gnt;
         if (i_gnt) begin
            irsp_data_o <= g_fwd ? rd_masked : 32'h0;
            irsp_err_o  <= g_mis;
         end
         if (d_gnt) begin
            drsp_data_o <= (g_fwd && !g_write) ? rd_masked : 32'h0;
            drsp_err_o  <= g_mis;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then held-request random traffic, checked against a
// byte-array memory model and the grant rules evaluated per cycle.
module tb_mem_arbiter;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam int LIM = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_i = 1'b1;
   logic        ivld = 1'b0, dvld = 1'b0, dwr = 1'b0;
   logic [31:0] iaddr = 32'h0, daddr = 32'h0, dwdata = 32'h0;
   logic [1:0]  isize = SZ_W, dsize = SZ_W;
   logic        irdy, drdy, irsp_vld, irsp_err, drsp_vld, drsp_err;
   logic [31:0] irsp_dat, drsp_dat;
   logic [31:0] m_rd_addr, m_rd_data, m_wr_addr, m_wr_data;
   logic [1:0]  m_rd_size, m_wr_size;
   logic        m_wr_en;

   mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk_i(clk), .reset_i(reset_i),
      .ireq_valid_i(ivld), .ireq_ready_o(irdy), .ireq_addr_i(iaddr), .ireq_size_i(isize),
      .irsp_valid_o(irsp_vld), .irsp_data_o(irsp_dat), .irsp_err_o(irsp_err),
      .dreq_valid_i(dvld), .dreq_ready_o(drdy), .dreq_write_i(dwr), .dreq_addr_i(daddr),
      .dreq_size_i(dsize), .dreq_wdata_i(dwdata),
      .drsp_valid_o(drsp_vld), .drsp_data_o(drsp_dat), .drsp_err_o(drsp_err),
      .memif_rd_addr(m_rd_addr), .memif_rd_size(m_rd_size), .memif_rd_data(m_rd_data),
      .memif_wr_addr(m_wr_addr), .memif_wr_size(m_wr_size), .memif_wr_data(m_wr_data),
      .memif_wr_enable(m_wr_en)
   );

   // Second instance: STARVE_LIMIT = 0, both ports always requesting.
   logic        z_irdy, z_drdy, z_irsp_vld, z_irsp_err, z_drsp_vld, z_drsp_err;
   logic [31:0] z_irsp_dat, z_drsp_dat, z_rd_addr, z_wr_addr, z_wr_data;
   logic [1:0]  z_rd_size, z_wr_size;
   logic        z_wr_en;

   mem_arbiter #(.STARVE_LIMIT(0)) dut_z (
      .clk_i(clk), .reset_i(reset_i),
      .ireq_valid_i(1'b1), .ireq_ready_o(z_irdy), .ireq_addr_i(32'h0), .ireq_size_i(SZ_W),
      .irsp_valid_o(z_irsp_vld), .irsp_data_o(z_irsp_dat), .irsp_err_o(z_irsp_err),
      .dreq_valid_i(1'b1), .dreq_ready_o(z_drdy), .dreq_write_i(1'b0), .dreq_addr_i(32'h4),
      .dreq_size_i(SZ_W), .dreq_wdata_i(32'h0),
      .drsp_valid_o(z_drsp_vld), .drsp_data_o(z_drsp_dat), .drsp_err_o(z_drsp_err),
      .memif_rd_addr(z_rd_addr), .memif_rd_size(z_rd_size), .memif_rd_data(32'h0),
      .memif_wr_addr(z_wr_addr), .memif_wr_size(z_wr_size), .memif_wr_data(z_wr_data),
      .memif_wr_enable(z_wr_en)
   );

   function automatic logic [7:0] fill(input int i);
      return 8'(i * 37 + 11);
   endfunction

   // Memory array seen by the DUT: combinational read, write committed at the clock edge.
   logic [7:0] mem_arr [0:1023];
   logic       fill_en = 1'b0;
   logic [9:0] ra, wa;
   assign ra = m_rd_addr[9:0];
   assign wa = m_wr_addr[9:0];

   always_comb begin
      m_rd_data = 32'h0;
      case (m_rd_size)
         SZ_B:    m_rd_data = {24'h0, mem_arr[ra]};
         SZ_H:    m_rd_data = {16'h0, mem_arr[ra + 10'd1], mem_arr[ra]};
         default: m_rd_data = {mem_arr[ra + 10'd3], mem_arr[ra + 10'd2], mem_arr[ra + 10'd1], mem_arr[ra]};
      endcase
   end

   always @(posedge clk) begin
      if (fill_en) begin
         for (int i = 0; i < 1024; i++) mem_arr[i] <= fill(i);
      end else if (m_wr_en) begin
         mem_arr[wa] <= m_wr_data[7:0];
         if (m_wr_size != SZ_B) mem_arr[wa + 10'd1] <= m_wr_data[15:8];
         if (m_wr_size == SZ_W) begin
            mem_arr[wa + 10'd2] <= m_wr_data[23:16];
            mem_arr[wa + 10'd3] <= m_wr_data[31:24];
         end
      end
   end

   // Reference model state
   logic [7:0]  ref_mem [0:1023];
   int          run = 0;
   logic [31:0] e_idat = 0, e_ddat = 0;
   logic        e_ivld = 0, e_dvld = 0, e_ierr = 0, e_derr = 0;
   logic        obs_ig, obs_dg;
   int          n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] s);
      return (s == SZ_B) ? 1 : (s == SZ_H) ? 2 : 4;
   endfunction

   function automatic logic is_mis(input logic [31:0] a, input logic [1:0] s);
      return (a % nbytes(s)) != 0;
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] s);
      logic [31:0] v = 32'h0;
      for (int b = 0; b < nbytes(s); b++) v[8*b +: 8] = ref_mem[10'(a + 32'(b))];
      return v;
   endfunction

   task automatic ref_write(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
      for (int b = 0; b < nbytes(s); b++) ref_mem[10'(a + 32'(b))] = d[8*b +: 8];
   endtask

   // One clock cycle: inputs already driven after the falling edge.
   task automatic step();
      logic eig, edg, wr, mis;
      logic [31:0] a, rd;
      logic [1:0]  s;
      #2;
      eig = !reset_i && ivld && (!dvld || run == LIM);
      edg = !reset_i && dvld && !eig;
      obs_ig = irdy;
      obs_dg = drdy;
      chk("ireq_ready", {31'h0, irdy}, {31'h0, eig});
      chk("dreq_ready", {31'h0, drdy}, {31'h0, edg});
      if (!reset_i) begin
         chk("lim0_ireq_ready", {31'h0, z_irdy}, 32'h1);
         chk("lim0_dreq_ready", {31'h0, z_drdy}, 32'h0);
      end
      a   = edg ? daddr : iaddr;
      s   = edg ? dsize : isize;
      wr  = edg && dwr;
      mis = is_mis(a, s);
      chk("wr_enable", {31'h0, m_wr_en}, {31'h0, wr && !mis});
      rd = (mis || wr) ? 32'h0 : ref_read(a, s);
      if (wr && !mis) ref_write(a, s, dwdata);
      if (reset_i) begin
         run = 0;
         {e_ivld, e_dvld, e_ierr, e_derr} = 4'b0;
         e_idat = 0;
         e_ddat = 0;
      end else begin
         run = (edg && ivld) ? run + 1 : 0;
         e_ivld = eig;
         e_dvld = edg;
         if (eig) begin e_idat = rd; e_ierr = mis; end
         if (edg) begin e_ddat = rd; e_derr = mis; end
      end
      @(posedge clk);
      #1;
      chk("irsp_valid", {31'h0, irsp_vld}, {31'h0, e_ivld});
      chk("irsp_data",  irsp_dat, e_idat);
      chk("irsp_err",   {31'h0, irsp_err}, {31'h0, e_ierr});
      chk("drsp_valid", {31'h0, drsp_vld}, {31'h0, e_dvld});
      chk("drsp_data",  drsp_dat, e_ddat);
      chk("drsp_err",   {31'h0, drsp_err}, {31'h0, e_derr});
      @(negedge clk);
   endtask

   task automatic dreq(input logic w, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
      dvld = 1'b1; dwr = w; daddr = a; dsize = s; dwdata = d;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = fill(i);
      @(negedge clk);
      fill_en = 1'b1;
      step();
      fill_en = 1'b0;
      step();
      step();
      reset_i = 1'b0;

      // Single fetch of a known instruction word
      dreq(1'b1, 32'h0001_0000, SZ_W, 32'h0000_0513);
      step();
      dvld = 1'b0;
      ivld = 1'b1; iaddr = 32'h0001_0000; isize = SZ_W;
      step();
      chk("fetch_word", irsp_dat, 32'h0000_0513);
      ivld = 1'b0;

      // Store then byte load
      dreq(1'b1, 32'h100, SZ_W, 32'hDEAD_BEEF);
      step();
      chk("store_ack_data", drsp_dat, 32'h0);
      dreq(1'b0, 32'h101, SZ_B, 32'h0);
      step();
      chk("load_byte", drsp_dat, 32'h0000_00BE);

      // Misaligned half store leaves memory untouched
      dreq(1'b1, 32'h203, SZ_H, 32'h0000_AAAA);
      step();
      chk("mis_store_err", {31'h0, drsp_err}, 32'h1);
      dreq(1'b0, 32'h202, SZ_H, 32'h0);
      step();
      chk("mis_store_mem", drsp_dat, {16'h0, fill(32'h203), fill(32'h202)});
      dvld = 1'b0;
      step();

      // Both requesting continuously: D,D,D,D,I repeating
      ivld = 1'b1; iaddr = 32'h80; isize = SZ_W;
      dreq(1'b0, 32'h40, SZ_W, 32'h0);
      for (int k = 0; k < 15; k++) begin
         step();
         chk("starve_pattern", {31'h0, obs_ig}, {31'h0, (k % 5) == 4});
      end

      // Reset while a store is being requested, after the counter has advanced
      dvld = 1'b0; ivld = 1'b0;
      step();
      ivld = 1'b1;
      dreq(1'b0, 32'h40, SZ_W, 32'h0);
      step();
      step();
      reset_i = 1'b1;
      dreq(1'b1, 32'h300, SZ_W, 32'h1234_5678);
      step();
      reset_i = 1'b0;
      ivld = 1'b0;
      dreq(1'b0, 32'h300, SZ_W, 32'h0);
      step();
      chk("reset_no_write", drsp_dat,
          {fill(32'h303), fill(32'h302), fill(32'h301), fill(32'h300)});
      ivld = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("post_reset_pattern", {31'h0, obs_ig}, {31'h0, k == 4});
      end

      // Random traffic; an ungranted request is held stable
      ivld = 1'b0; dvld = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!(ivld && !obs_ig)) begin
            ivld  = ($urandom_range(0, 3) != 0);
            iaddr = $urandom_range(0, 1023);
            isize = 2'($urandom_range(0, 2));
         end
         if (!(dvld && !obs_dg)) begin
            dreq(1'($urandom_range(0, 1)), $urandom_range(0, 1023), 2'($urandom_range(0, 2)), $urandom);
            dvld = ($urandom_range(0, 3) != 0);
         end
         obs_ig = 1'b0;
         obs_dg = 1'b0;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
